// File: rtl/toggle_xfer_arb.sv
// toggle_xfer_arb: round-robin arbiter sharing one toggle-synchronizer crossing among N event sources
// Ports: clk, rst_n (async, active-low), en (grant enable), req[N] (event pulses),
//        ack_tog (synchronized returned toggle, only with TOGGLE_ARB_ACK_EN),
//        tog_out (toggle to synchronizer), id_out (last winner), gnt[N] (grant pulse),
//        busy (spacing/ack interval running), ovf[N] (dropped-event pulse).
// Build option: define TOGGLE_ARB_ACK_EN for closed-loop ack spacing instead of the GAP countdown.
module toggle_xfer_arb #(
  parameter int N   = 4,
  parameter int GAP = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
`ifdef TOGGLE_ARB_ACK_EN
  input  logic           ack_tog,
`endif
  output logic           tog_out,
  output logic [IDW-1:0] id_out,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic [N-1:0]   ovf
);
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_ACK} state_t;
  state_t state, state_n;
  logic [N-1:0] pending, win_oh;
  logic [IDW-1:0] ptr, win, idx;
  logic [7:0] cnt, cnt_n;
  logic any, slot, grant;
  // scan from the farthest slot back to ptr so the nearest pending requester wins
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (pending[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
`ifdef TOGGLE_ARB_ACK_EN
  assign slot = state == IDLE || (state == HOLD && cnt == 8'd0) || (state == WAIT_ACK && ack_tog == tog_out);
`else
  assign slot = state == IDLE || (state == HOLD && cnt == 8'd0);
`endif
  assign grant  = slot && en && any;
  assign win_oh = grant ? (N'(1) << win) : '0;
  assign busy   = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
`ifdef TOGGLE_ARB_ACK_EN
    if (grant) state_n = WAIT_ACK;
`else
    if (grant) state_n = HOLD;
`endif
    else if (slot) state_n = IDLE;
    if (grant) cnt_n = 8'(GAP - 1);
    else if (state == HOLD && cnt != 8'd0) cnt_n = cnt - 8'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // a req landing on its own grant edge re-arms pending without counting as an overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      ovf     <= '0;
      gnt     <= '0;
      tog_out <= 1'b0;
      id_out  <= '0;
      ptr     <= '0;
    end else begin
      pending <= (pending & ~win_oh) | req;
      ovf     <= req & pending & ~win_oh;
      gnt     <= win_oh;
      if (grant) begin
        tog_out <= ~tog_out;
        id_out  <= win;
        ptr     <= (win == IDW'(N - 1)) ? '0 : win + 1'b1;
      end
    end
endmodule

// File: tb/tb_toggle_xfer_arb.sv
// tb_toggle_xfer_arb: directed and random stimulus against a spacing-based reference model
module tb_toggle_xfer_arb;
  localparam int N = 4;
  localparam int GAP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic [N-1:0] req = '0;
  logic tog_out, busy;
  logic [1:0] id_out;
  logic [N-1:0] gnt, ovf;
  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] pend_m, gnt_m, ovf_m;
  logic tog_m;
  logic [1:0] id_m;
  int ptr_m, last_m, e_m;
  toggle_xfer_arb #(.N(N), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .tog_out(tog_out), .id_out(id_out), .gnt(gnt), .busy(busy), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    check("tog_out", 32'(tog_out), 32'(tog_m));
    check("id_out", 32'(id_out), 32'(id_m));
    check("gnt", 32'(gnt), 32'(gnt_m));
    check("ovf", 32'(ovf), 32'(ovf_m));
    check("busy", 32'(busy), 32'((e_m - last_m) < GAP));
  endtask
  task automatic model_reset();
    pend_m = '0; gnt_m = '0; ovf_m = '0; tog_m = 1'b0; id_m = '0;
    ptr_m = 0; last_m = -1000; e_m = 0;
  endtask
  // a grant happens whenever enabled, something is pending and GAP edges have passed since the last flip
  task automatic cycle(input logic en_v, input logic [N-1:0] req_v);
    logic [N-1:0] oh;
    int w;
    en = en_v;
    req = req_v;
    @(posedge clk);
    e_m++;
    oh = '0;
    w = -1;
    if (en_v && pend_m != 0 && e_m - last_m >= GAP) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && pend_m[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      oh[w] = 1'b1;
      tog_m = ~tog_m;
      id_m = 2'(w);
      ptr_m = (w + 1) % N;
      last_m = e_m;
    end
    ovf_m = req_v & pend_m & ~oh;
    pend_m = (pend_m & ~oh) | req_v;
    gnt_m = oh;
    #1;
    check_all();
  endtask
  task automatic do_reset();
    req = '0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    do_reset();
    repeat (8) cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0100);
    repeat (8) cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b1111);
    repeat (20) cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0001);
    cycle(1'b1, 4'b0010);
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0010);
    repeat (12) cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b1000);
    cycle(1'b1, 4'b1000);
    repeat (10) cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0011);
    repeat (10) cycle(1'b0, 4'b0000);
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0000);
    do_reset();
    repeat (6) cycle(1'b1, 4'b0000);
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 9) != 0, r);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/toggle_xfer_arb.md
# toggle_xfer_arb

Round-robin arbiter and sequencer that shares one toggle-synchronizer crossing between N source-domain event requesters. Each accepted event flips the single toggle line (`tog_out`, driving the synchronizer's `sig_a`) and presents the winner's index on `id_out` for the destination to decode. The block then enforces a minimum toggle spacing so the slower destination clock never misses an edge. It sits entirely in the source clock domain, directly upstream of the toggle synchronizer.

## Interface
- `N`, 4: number of requesters (2..16).
- `GAP`, 4: minimum source cycles between consecutive `tog_out` flips (2..255); size it for at least 3 destination-clock edges.
- `IDW`, `$clog2(N)`: width of `id_out`.
- `clk`  in  1  source clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  grant enable; 0 blocks new grants while events are still captured.
- `req`  in  N  single-cycle event pulses, one per requester.
- `ack_tog`  in  1  returned toggle from the destination, already synchronized into `clk`; present only with `TOGGLE_ARB_ACK_EN`.
- `tog_out`  out  1  toggle line to the synchronizer.
- `id_out`  out  IDW  index of the last granted requester; stable until the next flip.
- `gnt`  out  N  one-hot, 1-cycle pulse in the cycle `tog_out` flips.
- `busy`  out  1  high while the spacing or ack interval is running.
- `ovf`  out  N  1-cycle pulse when an event is dropped because that requester was already pending.

## Operation
- `pending[N-1:0]`: a sticky bit per requester, set by `req[i]` and cleared when requester i is granted.
- `req[i]` in the same cycle its pending bit is cleared by a grant sets the bit again; this is a new event with no `ovf`.
- `req[i]` while `pending[i]`=1 and not being granted: `ovf[i]`=1 for that cycle and the event is lost.
- Round-robin search starts at pointer `ptr`, reset value 0. After granting i, `ptr` = (i+1) mod N.
- FSM states:
  - IDLE: if `en` and any pending bit is set, grant.
  - HOLD: count down; when the count reaches 0, grant if `en` and a bit is pending, else go to IDLE.
  - WAIT_ACK (ack build only): when `ack_tog`==`tog_out`, grant if eligible, else go to IDLE.
- Grant, registered in one edge:
  - `tog_out` inverts, `id_out` takes the winner's index, and `gnt[winner]`=1.
  - `pending[winner]` clears and `busy`=1.
  - Next state is HOLD with count=GAP-1 (default build) or WAIT_ACK (ack build).
- `busy`=0 only in IDLE.
- `en` deasserted mid-HOLD: the countdown completes and the FSM goes to IDLE without granting.
- Reset values: `tog_out`=0, `id_out`=0, `gnt`=0, `ovf`=0, `busy`=0, `pending`=0, `ptr`=0, state IDLE.
- Reset mid-operation discards all pending events and returns `tog_out` to 0. The synchronizer's destination side must be reset together with this block.

## Timing
- Latency: `req` at edge k gives `gnt`/flip at edge k+1 when the FSM is in IDLE (one cycle to register pending, then the grant at the next edge).
- Default build: consecutive flips are exactly GAP cycles apart under continuous demand, and never fewer.
- Ack build: the next flip is no earlier than 1 cycle after `ack_tog` matches `tog_out`.
- `id_out` changes only on the edge where `tog_out` flips. It is held for at least GAP cycles (default) or until ack (ack build).
- `gnt` and `ovf` are registered, 1-cycle pulses.

## Configuration
- `TOGGLE_ARB_ACK_EN` defined:
  - The `ack_tog` port exists.
  - Spacing is closed-loop via WAIT_ACK and `GAP` is unused.
  - `ack_tog` must reset to 0.
- `TOGGLE_ARB_ACK_EN` undefined: no `ack_tog` port and no WAIT_ACK state; spacing is fixed by the `GAP` countdown.

## Test plan
- Reset/single: N=4, GAP=4, `req`=4'b0100 for one cycle at edge 10 -> `tog_out` 0→1 and `id_out`=2 at edge 12, `gnt`=4'b0100 for 1 cycle, `busy` high for edges 12..15.
- Round-robin: `req`=4'b1111 in one cycle -> grants in order 0,1,2,3 at edges t, t+4, t+8, t+12, with `tog_out` toggling each time; `ptr` then wraps to 0.
- Overflow: `req[1]` pulsed twice while `pending[1]`=1 and requester 0 holds the channel -> `ovf`=4'b0010 on the second pulse only; requester 1 is granted once.
- Same-cycle regrant: `req[3]` asserted on its grant edge -> `pending[3]` re-set, no `ovf`, second grant GAP cycles later.
- Enable/reset: `en`=0 with 4'b0011 pending -> no flips and `busy`=0; then `rst_n` pulsed low mid-HOLD -> all outputs 0 asynchronously and `pending` cleared.
- Ack build: `ack_tog` held 0 after the first flip -> no second grant for 50 cycles; set `ack_tog`=1 -> next grant 1 cycle later.
